// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch (I)
// and data (D) ports: D-priority with a starvation cap, one outstanding transaction.
module mem_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_starve;
    logic              r_drop;
    logic              r_d_wr;
    logic              r_i_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    logic w_elig_d;
    logic w_elig_i;
    logic w_can_issue;
    logic w_cap;
    logic w_grant_d;
    logic w_grant_i;

    // A port that completes this cycle is masked by its own done pulse so it
    // is never re-issued on the stale request it still holds.
    assign w_elig_d    = d_req & ~r_d_done;
    assign w_elig_i    = i_req & ~r_i_done & ~i_flush;
    assign w_can_issue = rst & (r_state == IDLE) & ~mem_busy;
    assign w_cap       = w_elig_i & (r_starve == STARVE_LIM);
    assign w_grant_d   = w_can_issue & w_elig_d & ~w_cap;
    assign w_grant_i   = w_can_issue & w_elig_i & ~w_grant_d;

    assign mem_en  = w_grant_d | w_grant_i;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign err     = r_err;
    assign i_stall = i_req & ~r_i_done;
    assign d_stall = d_req & ~r_d_done;

    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_d) begin
            mem_wr    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_grant_i) begin
            mem_addr  = i_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_starve  <= 4'd0;
            r_drop    <= 1'b0;
            r_d_wr    <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_err     <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_err    <= ((r_state == IDLE) & mem_done) | (mem_en & mem_addr[0]);

            if (!i_req || w_grant_i) begin
                r_starve <= 4'd0;
            end else if (w_grant_d && w_elig_i && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_d) begin
                        r_state <= WAIT_D;
                        r_d_wr  <= d_wr;
                    end else if (w_grant_i) begin
                        r_state <= WAIT_I;
                    end
                end
                WAIT_I: begin
                    // A redirect seen at any point up to completion discards the fetch.
                    if (mem_done) begin
                        r_state <= IDLE;
                        r_drop  <= 1'b0;
                        if (!(r_drop || i_flush)) begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= mem_rdata;
                        end
                    end else if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (mem_done) begin
                        r_state   <= IDLE;
                        r_d_done  <= 1'b1;
                        r_d_rdata <= r_d_wr ? '0 : mem_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, starvation sequence, and random
// stimulus checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, d_req, d_wr, mem_busy, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst; logic ireq; logic [15:0] iaddr; logic ifl;
        logic dreq; logic dwr; logic [15:0] daddr; logic [15:0] dwd;
        logic busy; logic mdone; logic [15:0] mrd;
        logic en; logic wr; logic [15:0] addr; logic [15:0] wd;
        logic idone; logic [15:0] irdata; logic istall;
        logic ddone; logic [15:0] drdata; logic dstall; logic err;
    } vec_t;

    function automatic vec_t mk(
        input int r, input int iq, input int ia, input int fl,
        input int dq, input int dw, input int da, input int dd,
        input int bz, input int md, input int mr,
        input int en, input int wr, input int ad, input int wd,
        input int idn, input int ird, input int ist,
        input int ddn, input int drd, input int dst, input int er);
        vec_t v;
        v.rst = r[0];  v.ireq = iq[0]; v.iaddr = ia[15:0]; v.ifl = fl[0];
        v.dreq = dq[0]; v.dwr = dw[0]; v.daddr = da[15:0]; v.dwd = dd[15:0];
        v.busy = bz[0]; v.mdone = md[0]; v.mrd = mr[15:0];
        v.en = en[0]; v.wr = wr[0]; v.addr = ad[15:0]; v.wd = wd[15:0];
        v.idone = idn[0]; v.irdata = ird[15:0]; v.istall = ist[0];
        v.ddone = ddn[0]; v.drdata = drd[15:0]; v.dstall = dst[0]; v.err = er[0];
        return v;
    endfunction

    // Reference model state: who owns the memory, and the expected registered outputs.
    int          m_owner;      // 0 none, 1 fetch, 2 data
    bit          m_owner_wr, m_drop;
    int          m_starve;
    bit          m_idone, m_ddone, m_err;
    logic [15:0] m_irdata, m_drdata;

    task automatic model_reset();
        m_owner = 0; m_owner_wr = 0; m_drop = 0; m_starve = 0;
        m_idone = 0; m_ddone = 0; m_err = 0; m_irdata = '0; m_drdata = '0;
    endtask

    task automatic model_cycle(input int cyc);
        bit want_d, want_i, e_wr, n_err;
        int pick;
        logic [15:0] e_addr, e_wd;
        want_d = d_req && !m_ddone;
        want_i = i_req && !m_idone && !i_flush;
        pick = 0;
        if (m_owner == 0 && !mem_busy) begin
            if (want_d && !(want_i && m_starve == STARVE)) pick = 2;
            else if (want_i) pick = 1;
        end
        e_addr = (pick == 2) ? d_addr : (pick == 1) ? i_addr : 16'h0;
        e_wd   = (pick == 2) ? d_wdata : 16'h0;
        e_wr   = (pick == 2) && d_wr;
        chk($sformatf("rnd%0d mem", cyc), {mem_en, mem_wr, mem_addr, mem_wdata},
            {pick != 0, e_wr, e_addr, e_wd});
        chk($sformatf("rnd%0d iport", cyc), {i_done, i_rdata, i_stall},
            {m_idone, m_irdata, i_req && !m_idone});
        chk($sformatf("rnd%0d dport", cyc), {d_done, d_rdata, d_stall},
            {m_ddone, m_drdata, d_req && !m_ddone});
        chk($sformatf("rnd%0d err", cyc), err, m_err);

        n_err = (m_owner == 0 && mem_done) || (pick != 0 && e_addr[0]);
        m_idone = 0;
        m_ddone = 0;
        if (m_owner == 1) begin
            if (mem_done) begin
                if (!m_drop && !i_flush) begin
                    m_idone = 1;
                    m_irdata = mem_rdata;
                end
                m_owner = 0;
                m_drop = 0;
            end else if (i_flush) begin
                m_drop = 1;
            end
        end else if (m_owner == 2) begin
            if (mem_done) begin
                m_ddone = 1;
                m_drdata = m_owner_wr ? 16'h0 : mem_rdata;
                m_owner = 0;
            end
        end else if (pick != 0) begin
            m_owner = pick;
            m_owner_wr = e_wr;
        end
        if (!i_req || pick == 1) m_starve = 0;
        else if (pick == 2 && want_i) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
        m_err = n_err;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t e;
        int   grants[$];
        int   exp_pat[8] = '{2, 2, 2, 1, 2, 2, 2, 1};
        bit   saw;

        rst = 0; i_req = 0; i_addr = 0; i_flush = 0; d_req = 0; d_wr = 0;
        d_addr = 0; d_wdata = 0; mem_busy = 0; mem_done = 0; mem_rdata = 0;

        //          rst iq iaddr   fl dq dw daddr   dwdata  bz md mrdata   en wr addr    wdata   idn irdata  ist ddn drdata  dst err
        tbl.push_back(mk(0, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 1, 0, 'h0010, 'h0000, 0, 'h0000, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 1, 'hABCD, 0, 0, 'h0000, 'h0000, 0, 'h0000, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0010, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 1, 'hABCD, 0, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0020, 0, 1, 1, 'h0100, 'h1234, 0, 0, 'h0000, 1, 1, 'h0100, 'h1234, 0, 'hABCD, 1, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 1, 'h0020, 0, 1, 1, 'h0100, 'h1234, 0, 1, 'h7777, 0, 0, 'h0000, 'h0000, 0, 'hABCD, 1, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 1, 'h0020, 0, 1, 1, 'h0100, 'h1234, 0, 0, 'h0000, 1, 0, 'h0020, 'h0000, 0, 'hABCD, 1, 1, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0020, 0, 0, 0, 'h0000, 'h0000, 0, 1, 'h2222, 0, 0, 'h0000, 'h0000, 0, 'hABCD, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0020, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 1, 'h2222, 0, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0030, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 1, 0, 'h0030, 'h0000, 0, 'h2222, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0030, 1, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h2222, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0040, 0, 0, 0, 'h0000, 'h0000, 0, 1, 'h5555, 0, 0, 'h0000, 'h0000, 0, 'h2222, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0040, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 1, 0, 'h0040, 'h0000, 0, 'h2222, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 'h0040, 0, 0, 0, 'h0000, 'h0000, 0, 1, 'h0BEE, 0, 0, 'h0000, 'h0000, 0, 'h2222, 1, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 'h0040, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 1, 'h0BEE, 0, 0, 'h0000, 0, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0200, 'h0000, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0200, 'h0000, 0, 0, 'h0000, 1, 0, 'h0200, 'h0000, 0, 'h0BEE, 0, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0200, 'h0000, 0, 1, 'h3C3C, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0200, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 1, 'h3C3C, 0, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0003, 'h0000, 0, 0, 'h0000, 1, 0, 'h0003, 'h0000, 0, 'h0BEE, 0, 0, 'h3C3C, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0003, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 0, 'h3C3C, 1, 1));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 0, 'h0003, 'h0000, 0, 1, 'h1111, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 0, 'h3C3C, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0BEE, 0, 1, 'h1111, 0, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 1, 1, 'h0300, 'hAAAA, 0, 0, 'h0000, 1, 1, 'h0300, 'hAAAA, 0, 'h0BEE, 0, 0, 'h1111, 1, 0));
        tbl.push_back(mk(0, 0, 'h0000, 0, 1, 1, 'h0300, 'hAAAA, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 0, 0, 'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 0, 1, 'h4321, 0, 0, 'h0000, 'h0000, 0, 'h0000, 0, 0, 'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 0, 0, 'h0000, 0, 1));
        tbl.push_back(mk(1, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0, 'h0000, 0, 0, 'h0000, 0, 0));

        foreach (tbl[k]) begin
            e = tbl[k];
            if (k != 0) begin
                @(posedge clk);
                #1;
            end
            rst = e.rst; i_req = e.ireq; i_addr = e.iaddr; i_flush = e.ifl;
            d_req = e.dreq; d_wr = e.dwr; d_addr = e.daddr; d_wdata = e.dwd;
            mem_busy = e.busy; mem_done = e.mdone; mem_rdata = e.mrd;
            @(negedge clk);
            chk($sformatf("tbl%0d mem", k), {mem_en, mem_wr, mem_addr, mem_wdata}, {e.en, e.wr, e.addr, e.wd});
            chk($sformatf("tbl%0d iport", k), {i_done, i_rdata, i_stall}, {e.idone, e.irdata, e.istall});
            chk($sformatf("tbl%0d dport", k), {d_done, d_rdata, d_stall}, {e.ddone, e.drdata, e.dstall});
            chk($sformatf("tbl%0d err", k), err, e.err);
        end

        // Starvation: both ports held; memory busy in each completion cycle so
        // the done-mask never hands the fetch a free slot.
        @(posedge clk);
        #1;
        i_req = 1; i_addr = 16'h0050; i_flush = 0;
        d_req = 1; d_wr = 0; d_addr = 16'h0060; d_wdata = 0;
        mem_busy = 0; mem_done = 0; mem_rdata = 16'h0F0F;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            saw = mem_en;
            if (mem_en) grants.push_back((mem_addr == 16'h0060) ? 2 : 1);
            @(posedge clk);
            #1;
            mem_done = saw;
            mem_busy = d_done | i_done;
        end
        chk("starve grant count", (grants.size() >= 8), 1'b1);
        for (int g = 0; g < 8; g++)
            if (g < grants.size()) chk($sformatf("starve grant%0d", g), grants[g], exp_pat[g]);

        i_req = 0; d_req = 0; mem_busy = 0; mem_done = 0;
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_req     = ($urandom_range(0, 9) < 7);
            i_addr    = 16'($urandom);
            i_flush   = ($urandom_range(0, 9) == 0);
            d_req     = ($urandom_range(0, 9) < 6);
            d_wr      = $urandom_range(0, 1) == 1;
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_busy  = ($urandom_range(0, 3) == 0);
            mem_done  = ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom);
            @(negedge clk);
            model_cycle(cyc);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
